// File: rtl/fan_drive.sv
// Fan PWM driver: 16-slot PWM with full-on spin-up kick and one-slot-per-period ramping.
// Optional tach stall detection is built when FAN_TACH_EN is defined.
module fan_drive #(
  parameter int SLOT_CYC     = 4,
  parameter int KICK_PERIODS = 2,
  parameter int STALL_WIN    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] crs,
  output logic       pwm,
  output logic [4:0] duty_o,
  output logic       busy
`ifdef FAN_TACH_EN
  ,
  input  logic       tach,
  output logic       stall
`endif
);

  localparam int SC_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int KC_W = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

  typedef enum logic [1:0] {IDLE, KICK, RUN} state_t;

  state_t            state, nxt_state;
  logic [SC_W-1:0]   slot_cnt;
  logic [3:0]        slot_idx;
  logic [KC_W-1:0]   kick_cnt, nxt_kick;
  logic [4:0]        nxt_duty, tgt_now, stepped;
  logic              period_end, nxt_busy;

  function automatic logic [4:0] sat_target(input logic [3:0] c);
    return (c > 4'd8) ? 5'd16 : {c, 1'b0};
  endfunction

  function automatic logic [4:0] step_toward(input logic [4:0] d, input logic [4:0] t);
    if (d < t)      return d + 5'd1;
    else if (d > t) return d - 5'd1;
    else            return d;
  endfunction

  assign period_end = (slot_idx == 4'd15) && (slot_cnt == SC_W'(SLOT_CYC - 1));
  assign tgt_now    = sat_target(crs);
  assign stepped    = step_toward(duty_o, tgt_now);

  always_comb begin
    nxt_state = state;
    nxt_duty  = duty_o;
    nxt_kick  = kick_cnt;
    nxt_busy  = busy;
    if (period_end) begin
      case (state)
        IDLE: if (tgt_now != 5'd0) begin
          nxt_state = KICK;
          nxt_kick  = KC_W'(KICK_PERIODS - 1);
          nxt_duty  = 5'd16;
        end
        KICK: begin
          nxt_duty = 5'd16;
          if (kick_cnt == '0) nxt_state = RUN;
          else                nxt_kick  = kick_cnt - KC_W'(1);
        end
        RUN: begin
          nxt_duty = stepped;
          if (stepped == 5'd0) nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
      // busy only changes when the target is sampled, i.e. at period end
      nxt_busy = (nxt_state == KICK) ||
                 ((nxt_state == RUN) && (nxt_duty != tgt_now));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
      slot_idx <= '0;
      duty_o   <= '0;
      busy     <= 1'b0;
      kick_cnt <= '0;
    end else begin
      if (slot_cnt == SC_W'(SLOT_CYC - 1)) begin
        slot_cnt <= '0;
        slot_idx <= slot_idx + 4'd1;
      end else begin
        slot_cnt <= slot_cnt + SC_W'(1);
      end
      state    <= nxt_state;
      duty_o   <= nxt_duty;
      kick_cnt <= nxt_kick;
      busy     <= nxt_busy;
    end
  end

  always_comb begin
    case (state)
      KICK:    pwm = 1'b1;
      RUN:     pwm = ({1'b0, slot_idx} < duty_o);
      default: pwm = 1'b0;
    endcase
  end

`ifdef FAN_TACH_EN
  localparam int WIN_W = (STALL_WIN > 1) ? $clog2(STALL_WIN) : 1;

  logic             tach_s1, tach_s2, tach_d, tach_rise;
  logic [7:0]       edge_cnt;
  logic [WIN_W-1:0] win_cnt;

  assign tach_rise = tach_s2 & ~tach_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tach_s1  <= 1'b0;
      tach_s2  <= 1'b0;
      tach_d   <= 1'b0;
      edge_cnt <= '0;
      win_cnt  <= '0;
      stall    <= 1'b0;
    end else begin
      tach_s1 <= tach;
      tach_s2 <= tach_s1;
      tach_d  <= tach_s2;
      if (state == KICK && nxt_state == RUN) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (state == RUN) begin
        if (period_end && win_cnt == WIN_W'(STALL_WIN - 1)) begin
          if (edge_cnt == 8'd0 && duty_o >= 5'd8) stall <= 1'b1;
          win_cnt  <= '0;
          edge_cnt <= '0;
        end else begin
          if (period_end) win_cnt <= win_cnt + WIN_W'(1);
          if (tach_rise && edge_cnt != 8'hFF) edge_cnt <= edge_cnt + 8'd1;
        end
      end
      // entering or sitting in IDLE clears the alarm; takes precedence over a set
      if (nxt_state == IDLE) stall <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fan_drive.sv
// Bench for fan_drive: directed vector table, reset corner sequences and randomized crs
// stimulus against a period-level reference model.
module tb_fan_drive;
  localparam int SLOT_CYC     = 4;
  localparam int KICK_PERIODS = 2;
  localparam int STALL_WIN    = 8;
  localparam int P            = 16 * SLOT_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] crs = 4'd0;
  logic       pwm;
  logic [4:0] duty_o;
  logic       busy;
`ifdef FAN_TACH_EN
  logic       tach = 1'b0;
  logic       stall;
  logic       tach_toggle = 1'b0;
`endif

  always #5 clk = ~clk;

  fan_drive #(.SLOT_CYC(SLOT_CYC), .KICK_PERIODS(KICK_PERIODS), .STALL_WIN(STALL_WIN)) dut (
    .clk(clk), .rst(rst), .crs(crs), .pwm(pwm), .duty_o(duty_o), .busy(busy)
`ifdef FAN_TACH_EN
    , .tach(tach), .stall(stall)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: mode 0 = idle, 1 = kick, 2 = run
  int m_phase = 0, m_mode = 0, m_kleft = 0, m_duty = 0, m_busy = 0;
  int m_stall = 0, m_win = 0, m_edges = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pwm();
    if (m_mode == 1) return 1;
    if (m_mode == 2) return ((m_phase / SLOT_CYC) < m_duty) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_edge();
    int t;
    if (rst) begin
      m_phase = 0; m_mode = 0; m_kleft = 0; m_duty = 0; m_busy = 0;
      m_stall = 0; m_win = 0; m_edges = 0;
    end else begin
      if (m_phase == P - 1) begin
        t = 2 * ((int'(crs) > 8) ? 8 : int'(crs));
        case (m_mode)
          0: if (t != 0) begin m_mode = 1; m_kleft = KICK_PERIODS; m_duty = 16; end
          1: begin
            m_kleft--;
            if (m_kleft == 0) begin m_mode = 2; m_win = 0; m_edges = 0; end
          end
          default: begin
            m_win++;
            if (m_win == STALL_WIN) begin
              if (m_edges == 0 && m_duty >= 8) m_stall = 1;
              m_win = 0; m_edges = 0;
            end
            if (m_duty < t) m_duty++;
            else if (m_duty > t) m_duty--;
            if (m_duty == 0) m_mode = 0;
          end
        endcase
        if (m_mode == 0) m_stall = 0;
        m_busy = (m_mode == 1 || (m_mode == 2 && m_duty != t)) ? 1 : 0;
      end
      m_phase = (m_phase + 1) % P;
    end
  endtask

  // one clock: model follows the inputs present at the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    check("pwm", int'(pwm), model_pwm());
    check("duty", int'(duty_o), m_duty);
    check("busy", int'(busy), m_busy);
`ifdef FAN_TACH_EN
    check("stall", int'(stall), m_stall);
    if (tach_toggle && (cyc % 16 == 0)) begin
      tach = ~tach;
      if (tach && m_mode == 2) m_edges++;
    end
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [3:0] crs;
    int         ncyc;
    int         duty;
    int         busy;
    int         pwm;
    string      name;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{4'd0,  320,     0,  0, 0, "quiet_idle"};
    tbl[1]  = '{4'd4,  1,       0,  0, 0, "req_before_pe"};
    tbl[2]  = '{4'd4,  63,      16, 1, 1, "kick_enter"};
    tbl[3]  = '{4'd4,  127,     16, 1, 1, "kick_hold"};
    tbl[4]  = '{4'd4,  1,       16, 1, 1, "run_enter"};
    tbl[5]  = '{4'd4,  8 * P,   8,  0, 1, "ramp_down_8"};
    tbl[6]  = '{4'd4,  32,      8,  0, 0, "half_duty_low"};
    tbl[7]  = '{4'd6,  32,      9,  1, 1, "ramp_up_9"};
    tbl[8]  = '{4'd6,  3 * P,   12, 0, 1, "settle_12"};
    tbl[9]  = '{4'd0,  2 * P,   10, 1, 1, "ramp_dn_10"};
    tbl[10] = '{4'd6,  2 * P,   12, 0, 1, "reverse_12"};
    tbl[11] = '{4'd0,  12 * P,  0,  0, 0, "ramp_to_idle"};
    tbl[12] = '{4'd0,  P,       0,  0, 0, "no_kick"};
    tbl[13] = '{4'd15, P,       16, 1, 1, "clamp_kick"};
    tbl[14] = '{4'd15, 2 * P,   16, 0, 1, "clamp_run"};
    tbl[15] = '{4'd15, 40,      16, 0, 1, "full_on_mid"};

    rst = 1'b1;
    run(2);
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty_o), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      crs = tbl[i].crs;
      run(tbl[i].ncyc);
      check({tbl[i].name, "_duty"}, int'(duty_o), tbl[i].duty);
      check({tbl[i].name, "_busy"}, int'(busy), tbl[i].busy);
      check({tbl[i].name, "_pwm"}, int'(pwm), tbl[i].pwm);
    end

    // reset in RUN: immediate abort
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_run_pwm", int'(pwm), 0);
    check("rst_run_duty", int'(duty_o), 0);
    // reset mid-kick
    crs = 4'd4;
    run(P + 30);
    check("kick_mid_pwm", int'(pwm), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_kick_pwm", int'(pwm), 0);
    check("rst_kick_duty", int'(duty_o), 0);
    check("rst_kick_busy", int'(busy), 0);
    // reset landing on a period end wins over the kick request
    run(P - 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_pe_duty", int'(duty_o), 0);
    check("rst_pe_busy", int'(busy), 0);
    step();
    check("rst_pe_after_pwm", int'(pwm), 0);

`ifdef FAN_TACH_EN
    rst = 1'b1; step(); rst = 1'b0;
    crs = 4'd8; tach_toggle = 1'b0;
    run(3 * P);
    run(7 * P);
    check("stall_pre", int'(stall), 0);
    run(P);
    check("stall_set", int'(stall), 1);
    crs = 4'd0;
    run(16 * P);
    check("stall_idle_clr", int'(stall), 0);
    crs = 4'd8; tach_toggle = 1'b1;
    run(3 * P + 20 * P);
    check("stall_tach_ok", int'(stall), 0);
    tach_toggle = 1'b0; tach = 1'b0;
    crs = 4'd0;
    run(20 * P);
`endif

    for (int s = 0; s < 40; s++) begin
      crs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        run(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      run(int'($urandom_range(1, 150)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
